rstatus_decoder: RTL
====================

Name: rstatus_decoder

Overview:
- Consumer side of the $rstatus overflow-code convention: writeback publishes codes 1=add, 2=addi, 3=sub, 4=mult, 5=div; this block decodes them back into events.
- Sits after writeback. Queues each nonzero status write with its PC in a small first-word-fall-through (FWFT) FIFO for the exception/debug reader (valid/ready).
- Keeps per-kind saturating event counters and a sticky "last status" register that drives the bex-pending indication.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 8, width of each per-kind event counter
PC_W, 32, width of the captured PC

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
wb_valid  in  1  writeback stage is writing $rstatus this cycle
wb_rstatus  in  32  value being written to $rstatus
wb_pc  in  PC_W  PC of the writing instruction
rd_valid  out  1  FIFO head valid
rd_ready  in  1  reader accepts head this cycle
rd_code  out  3  head code, wb_rstatus[2:0]
rd_kind  out  5  one-hot head kind {div,mult,sub,addi,add}; all zero when illegal
rd_illegal  out  1  head code is outside 1..5
rd_pc  out  PC_W  head PC
fifo_count  out  log2(DEPTH)+1  occupancy
overflow_lost  out  1  sticky: an event was dropped because the FIFO was full
cnt_sel  in  3  counter select: 1..5 = kind; other values read as 0
cnt_value  out  CNT_W  selected counter, combinational read
cnt_clr  in  1  clear the selected counter and overflow_lost
last_rstatus  out  32  most recent nonzero wb_rstatus
bex_pending  out  1  last_rstatus != 0
status_clr  in  1  clear last_rstatus

Behaviour:
- Reset (reset==0 at an edge):
  - FIFO empty, fifo_count=0, rd_valid=0.
  - All counters 0, overflow_lost=0, last_rstatus=0, bex_pending=0.
  - rd_code, rd_kind, rd_pc and rd_illegal are 0 while empty.
  - Reset mid-stream discards all queued entries. Reset overrides every other input.
- Event definition:
  - An event occurs when wb_valid=1 and wb_rstatus!=0.
  - wb_valid=1 with wb_rstatus==0 is not an event: no push, no count, last_rstatus unchanged.
- Decode:
  - Code 1..5 sets the matching rd_kind bit.
  - Any other nonzero value (including values with upper bits set) gives rd_illegal=1 and rd_kind=0.
  - rd_code always carries bits [2:0] of the value.
  - Illegal events are queued but increment no counter.
- FIFO:
  - FWFT: an event pushed at edge N is presented on the rd_* outputs after edge N (rd_valid=1 from that point).
  - A pop occurs when rd_valid && rd_ready at the edge.
  - Pointers wrap modulo DEPTH.
  - Full + event + pop in the same cycle: the pop frees a slot and the push is accepted; count stays at DEPTH.
  - Full + event with no pop: the event is dropped, overflow_lost is set, and the counter still increments; FIFO contents are unchanged.
  - Empty + rd_ready: no effect.
  - Push and pop in the same cycle at count between 1 and DEPTH-1: count is unchanged.
- Counters:
  - An event of kind k increments cnt[k], saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr zeroes cnt[cnt_sel] and clears overflow_lost.
  - If the cleared counter also gets an event in the same cycle, the result is 1 (clear first, then increment).
  - If the event also overflows the full FIFO in that cycle, overflow_lost ends at 1 (set wins over clear).
- last_rstatus:
  - Loads wb_rstatus on every event.
  - status_clr zeroes it; an event in the same cycle wins and loads the new value.
  - bex_pending is combinational from last_rstatus.
- Latency: all state updates take effect at the next edge; cnt_value and bex_pending are combinational from state.

Test Plan:
1. Reset with reset=0 -> fifo_count=0, rd_valid=0, cnt_value=0 for every cnt_sel, bex_pending=0.
2. wb_rstatus=3, wb_pc=0x40 for one cycle, rd_ready=0 -> next cycle rd_valid=1, rd_code=3, rd_kind=5'b00100, rd_pc=0x40, cnt_value(sel=3)=1, last_rstatus=3; assert rd_ready -> rd_valid=0.
3. Push 5 events (codes 1,2,4,5,1) with DEPTH=4 and rd_ready=0 -> fifo_count=4, overflow_lost=1, cnt(sel=1)=2; pop 4 -> codes returned in order 1,2,4,5.
4. Full FIFO plus an event of code 2 with rd_ready=1 in the same cycle -> no drop, fifo_count stays 4, overflow_lost stays 0, tail=code 2.
5. wb_rstatus=7, then wb_rstatus=0x100 -> both queued with rd_illegal=1, rd_kind=0; no counter changes; last_rstatus=0x100.
6. 300 add events with CNT_W=8 -> cnt(sel=1)=255; cnt_clr with an add event in the same cycle -> 1; status_clr with no event -> bex_pending=0.

Source files
------------

// File: rtl/rstatus_decoder.sv
// Decodes $rstatus overflow codes from writeback into a FWFT event FIFO, per-kind counters and a sticky status.
// Pushed events appear on rd_* the cycle after the edge; events arriving at a full FIFO without a pop are dropped and flagged.
module rstatus_decoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int PC_W  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wb_valid,
    input  logic [31:0]                wb_rstatus,
    input  logic [PC_W-1:0]            wb_pc,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [2:0]                 rd_code,
    output logic [4:0]                 rd_kind,
    output logic                       rd_illegal,
    output logic [PC_W-1:0]            rd_pc,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow_lost,
    input  logic [2:0]                 cnt_sel,
    output logic [CNT_W-1:0]           cnt_value,
    input  logic                       cnt_clr,
    output logic [31:0]                last_rstatus,
    output logic                       bex_pending,
    input  logic                       status_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = AW'(0) + (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       code_q [DEPTH];
    logic             ill_q  [DEPTH];
    logic [PC_W-1:0]  pc_q   [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             ovf_q;
    logic [31:0]      last_q;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];

    logic evt, evt_ill, empty, full, pop, push, drop;

    assign evt     = wb_valid && (wb_rstatus != 32'd0);
    assign evt_ill = wb_rstatus > 32'd5;
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL);
    assign pop     = !empty && rd_ready;
    assign push    = evt && (!full || pop);
    assign drop    = evt && full && !pop;

    // Clear is applied before the increment so clear+event leaves the counter at 1.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clr && cnt_sel == 3'(k + 1))
                cnt_d[k] = '0;
            if (evt && !evt_ill && wb_rstatus[2:0] == 3'(k + 1) && cnt_d[k] != CNT_MAX)
                cnt_d[k] = cnt_d[k] + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            last_q   <= '0;
            for (int k = 0; k < 5; k++)
                cnt_q[k] <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
            if (drop)
                ovf_q <= 1'b1;
            else if (cnt_clr)
                ovf_q <= 1'b0;
            if (evt)
                last_q <= wb_rstatus;
            else if (status_clr)
                last_q <= '0;
            for (int k = 0; k < 5; k++)
                cnt_q[k] <= cnt_d[k];
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            code_q[wr_ptr_q] <= wb_rstatus[2:0];
            ill_q[wr_ptr_q]  <= evt_ill;
            pc_q[wr_ptr_q]   <= wb_pc;
        end
    end

    always_comb begin
        rd_valid   = !empty;
        rd_code    = '0;
        rd_illegal = 1'b0;
        rd_pc      = '0;
        rd_kind    = '0;
        if (!empty) begin
            rd_code    = code_q[rd_ptr_q];
            rd_illegal = ill_q[rd_ptr_q];
            rd_pc      = pc_q[rd_ptr_q];
            if (!ill_q[rd_ptr_q])
                rd_kind = 5'd1 << (code_q[rd_ptr_q] - 3'd1);
        end
    end

    always_comb begin
        cnt_value = '0;
        if (cnt_sel >= 3'd1 && cnt_sel <= 3'd5)
            cnt_value = cnt_q[cnt_sel - 3'd1];
    end

    assign fifo_count    = count_q;
    assign overflow_lost = ovf_q;
    assign last_rstatus  = last_q;
    assign bex_pending   = (last_q != 32'd0);

endmodule
